alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Hardwired control unit that sequences the 32-bit datapath through instruction fetch (T0–T2) and execute (T3–T6) for register ALU, immediate, mul/div, nop and halt instructions.
- Replaces hand-driven per-state control signals with one FSM: it decodes IR and drives the datapath's register-select strobes, bus-source strobes, load enables, Read and ALU OP.
- Sits beside the datapath and shares its single clock.

Parameters:
- NREGS, 16, number of general registers; width of R_in/R_out one-hot vectors.
- OPW, 5, opcode/ALU OP width; IR[31:32-OPW].

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Clear  in  1  synchronous active-high reset.
- IR  in  32  current instruction from datapath IR: opcode[31:27], Ra[26:23], Rb[22:19], Rc[18:15].
- Mem_ready  in  1  memory read data valid on Mdatain this cycle.
- Stop  in  1  request to pause at next instruction boundary.
- PCout, ZHighout, ZLowout, MDRout, Cout  out  1 each  bus-source strobes.
- PCin, IRin, MARin, MDRin, Yin, ZHighin, ZLowin, HIin, LOin  out  1 each  load enables.
- IncPC, Read  out  1 each  PC increment select; memory read.
- R_in, R_out  out  NREGS  one-hot register load / drive selects.
- OP  out  OPW  ALU operation code.
- Run  out  1  high while executing; low in HALT or PAUSE.
- Illegal  out  1  one-cycle pulse on undefined opcode.

Behaviour:
- All control outputs are decoded from the registered state and IR, constant for a whole cycle; the datapath captures on the following rising edge. At most one bus-source strobe is high in any state.
- Clear=1 at an edge: state←RST regardless of current state, including mid-fetch or mid-execute. In RST every output is 0 except Run=1, OP=0. The next state is T0.
- T0: PCout, MARin, IncPC, ZLowin, ZHighin. If Stop=1, go to PAUSE with all strobes 0 and Run=0. Stay in PAUSE while Stop=1; return to T0 the cycle after Stop=0.
- T1: ZLowout, Read, MDRin held while Mem_ready=0; state stays T1. In the cycle Mem_ready=1, PCin also asserts; next state is T2. Fetch latency is 3 cycles plus wait cycles.
- T2: MDRout, IRin. Next state from the opcode on the IR input in the following cycle:
  - 11010 (nop) → T0.
  - 11011 (halt) → HALT. In HALT, Run=0 and all strobes are 0 until Clear.
  - Undefined opcode → Illegal pulses in T3 (one cycle), no register written, → T0.
- ALU R-format: add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011.
  - T3: R_out[Rb], Yin.
  - T4: R_out[Rc], OP=opcode, ZLowin, ZHighin.
  - T5: ZLowout, R_in[Ra] → T0.
- Immediate: addi 01100, andi 01101, ori 01110. T4 uses Cout instead of R_out[Rc]; OP = add 00011, and 01010, or 01011 respectively. T3 and T5 as R-format.
- neg 10001 / not 10010: T3 skipped (T2→T4). T4: R_out[Rb], OP=opcode, ZLowin. T5 as R-format.
- mul 01111 / div 10000:
  - T3: R_out[Ra], Yin.
  - T4: R_out[Rb], OP=opcode, ZLowin, ZHighin.
  - T5: ZLowout, LOin.
  - T6: ZHighout, HIin → T0.
- Instruction cycle counts: R-format/imm 6, neg/not 5, mul/div 7, plus fetch wait cycles.
- OP holds the last ALU value between T4s. Outside T4 it is don't-care for the datapath, but the RTL must hold it (no X).
- Stop is sampled only in T0; Stop raised mid-instruction completes that instruction first.
- Register indices ≥ NREGS select no register (R_in/R_out all zero).

Test Plan:
- Clear=1 two cycles → all strobes 0, Run=1; Clear=0 → T0 strobes (PCout, MARin, IncPC, ZLowin, ZHighin) next cycle.
- IR=0x4B320000 (rol R6,R6,R4), Mem_ready=1 → T3 R_out=0x0040+Yin; T4 R_out=0x0010, OP=01001; T5 R_in=0x0040; 6 cycles total.
- IR=0x61A7FFFB (addi R3,R4,-5) → T4 Cout=1, R_out=0, OP=00011; T5 R_in=0x0008.
- IR=0x79280000 (mul R2,R5) → T5 LOin, T6 ZHighout+HIin; no R_in bit ever set; 7 cycles.
- Mem_ready low 3 cycles in T1 → Read/MDRin held 4 cycles, PCin only in last; Clear asserted during the wait → RST next edge, Read=0.
- IR=0xD8000000 (halt) → Run=0 and outputs frozen for 20 cycles; Stop=1 during T5 of prior instruction → PAUSE after next T0; opcode 11111 → Illegal one cycle, no R_in.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Control bundle between the hardwired sequencer and the 32-bit datapath.
// The sequencer drives through the master modport. The datapath, or a bench, uses the slave modport.
interface alu_sequencer_if #(
    parameter int NREGS = 16,
    parameter int OPW   = 5
);
    logic [31:0]      IR;
    logic             Mem_ready;
    logic             Stop;
    logic             PCout, ZHighout, ZLowout, MDRout, Cout;
    logic             PCin, IRin, MARin, MDRin, Yin, ZHighin, ZLowin, HIin, LOin;
    logic             IncPC, Read;
    logic [NREGS-1:0] R_in, R_out;
    logic [OPW-1:0]   OP;
    logic             Run;
    logic             Illegal;

    modport master (
        input  IR, Mem_ready, Stop,
        output PCout, ZHighout, ZLowout, MDRout, Cout,
        output PCin, IRin, MARin, MDRin, Yin, ZHighin, ZLowin, HIin, LOin,
        output IncPC, Read, R_in, R_out, OP, Run, Illegal
    );

    modport slave (
        output IR, Mem_ready, Stop,
        input  PCout, ZHighout, ZLowout, MDRout, Cout,
        input  PCin, IRin, MARin, MDRin, Yin, ZHighin, ZLowin, HIin, LOin,
        input  IncPC, Read, R_in, R_out, OP, Run, Illegal
    );
endinterface

// File: rtl/alu_sequencer.sv
// Hardwired control FSM that drives the datapath through fetch (T0-T2) and execute (T3-T6).
// Strobes are decoded from the registered state and IR. OP is a register that holds its value between T4 states.
module alu_sequencer #(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic            Clock,
    input  logic            Clear,
    alu_sequencer_if.master ctl
);
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_PAUSE, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        C_ALU, C_IMM, C_UNARY, C_MULDIV, C_NOP, C_HALT, C_ILLEGAL
    } cls_e;

    localparam logic [OPW-1:0] OPC_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OPC_OR   = OPW'(5'b01011);
    localparam logic [OPW-1:0] OPC_AND  = OPW'(5'b01010);
    localparam logic [OPW-1:0] OPC_ADDI = OPW'(5'b01100);
    localparam logic [OPW-1:0] OPC_ANDI = OPW'(5'b01101);
    localparam logic [OPW-1:0] OPC_ORI  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OPC_MUL  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OPC_DIV  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OPC_NEG  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OPC_NOT  = OPW'(5'b10010);
    localparam logic [OPW-1:0] OPC_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OPC_HALT = OPW'(5'b11011);

    state_e         state;
    cls_e           cls;
    logic [OPW-1:0] opcode;
    logic [OPW-1:0] alu_op;
    logic [OPW-1:0] op_q;
    logic [3:0]     ra, rb, rc;
    logic           unused_ir;

    assign opcode    = ctl.IR[31 -: OPW];
    assign ra        = ctl.IR[26:23];
    assign rb        = ctl.IR[22:19];
    assign rc        = ctl.IR[18:15];
    assign unused_ir = ^ctl.IR[14:0];

    // Field values at or above NREGS select no register.
    function automatic logic [NREGS-1:0] reg_sel(input logic [3:0] idx);
        logic [NREGS-1:0] sel;
        sel = '0;
        if (32'(idx) < NREGS) sel[idx] = 1'b1;
        return sel;
    endfunction

    always_comb begin
        cls    = C_ILLEGAL;
        alu_op = opcode;
        case (opcode)
            OPW'(5'b00011), OPW'(5'b00100), OPW'(5'b00101), OPW'(5'b00110),
            OPW'(5'b00111), OPW'(5'b01000), OPW'(5'b01001), OPC_AND, OPC_OR:
                cls = C_ALU;
            OPC_ADDI: begin cls = C_IMM; alu_op = OPC_ADD; end
            OPC_ANDI: begin cls = C_IMM; alu_op = OPC_AND; end
            OPC_ORI:  begin cls = C_IMM; alu_op = OPC_OR;  end
            OPC_MUL, OPC_DIV: cls = C_MULDIV;
            OPC_NEG, OPC_NOT: cls = C_UNARY;
            OPC_NOP:  cls = C_NOP;
            OPC_HALT: cls = C_HALT;
            default:  cls = C_ILLEGAL;
        endcase
    end

    // NOTE: state and the OP register use non-blocking assignments, so every branch reads the pre-edge values.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            state <= S_RST;
            op_q  <= '0;
        end else begin
            case (state)
                S_RST:   state <= S_T0;
                S_T0:    state <= ctl.Stop ? S_PAUSE : S_T1;
                S_PAUSE: state <= ctl.Stop ? S_PAUSE : S_T0;
                S_T1:    state <= ctl.Mem_ready ? S_T2 : S_T1;
                S_T2: begin
                    case (cls)
                        C_NOP:   state <= S_T0;
                        C_HALT:  state <= S_HALT;
                        C_UNARY: begin state <= S_T4; op_q <= alu_op; end
                        default: state <= S_T3;
                    endcase
                end
                S_T3: begin
                    if (cls == C_ILLEGAL) begin
                        state <= S_T0;
                    end else begin
                        state <= S_T4;
                        op_q  <= alu_op;
                    end
                end
                S_T4:    state <= S_T5;
                S_T5:    state <= (cls == C_MULDIV) ? S_T6 : S_T0;
                S_T6:    state <= S_T0;
                S_HALT:  state <= S_HALT;
                default: state <= S_RST;
            endcase
        end
    end

    assign ctl.OP  = op_q;
    assign ctl.Run = (state != S_PAUSE) && (state != S_HALT);

    // NOTE: every output gets a default before the case, so a missing arm cannot infer a latch.
    always_comb begin
        ctl.PCout = 1'b0; ctl.ZHighout = 1'b0; ctl.ZLowout = 1'b0; ctl.MDRout = 1'b0;
        ctl.Cout  = 1'b0; ctl.PCin = 1'b0; ctl.IRin = 1'b0; ctl.MARin = 1'b0;
        ctl.MDRin = 1'b0; ctl.Yin = 1'b0; ctl.ZHighin = 1'b0; ctl.ZLowin = 1'b0;
        ctl.HIin  = 1'b0; ctl.LOin = 1'b0; ctl.IncPC = 1'b0; ctl.Read = 1'b0;
        ctl.R_in  = '0;   ctl.R_out = '0;  ctl.Illegal = 1'b0;
        case (state)
            S_T0: begin
                ctl.PCout = 1'b1; ctl.MARin = 1'b1; ctl.IncPC = 1'b1;
                ctl.ZLowin = 1'b1; ctl.ZHighin = 1'b1;
            end
            S_T1: begin
                ctl.ZLowout = 1'b1; ctl.Read = 1'b1; ctl.MDRin = 1'b1;
                ctl.PCin = ctl.Mem_ready;
            end
            S_T2: begin
                ctl.MDRout = 1'b1; ctl.IRin = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_ALU, C_IMM: begin ctl.R_out = reg_sel(rb); ctl.Yin = 1'b1; end
                    C_MULDIV:     begin ctl.R_out = reg_sel(ra); ctl.Yin = 1'b1; end
                    C_ILLEGAL:    ctl.Illegal = 1'b1;
                    default:      ;
                endcase
            end
            S_T4: begin
                ctl.ZLowin = 1'b1;
                case (cls)
                    C_ALU:    begin ctl.R_out = reg_sel(rc); ctl.ZHighin = 1'b1; end
                    C_IMM:    begin ctl.Cout = 1'b1; ctl.ZHighin = 1'b1; end
                    C_MULDIV: begin ctl.R_out = reg_sel(rb); ctl.ZHighin = 1'b1; end
                    C_UNARY:  ctl.R_out = reg_sel(rb);
                    default:  ;
                endcase
            end
            S_T5: begin
                ctl.ZLowout = 1'b1;
                if (cls == C_MULDIV) ctl.LOin = 1'b1;
                else                 ctl.R_in = reg_sel(ra);
            end
            S_T6: begin
                ctl.ZHighout = 1'b1; ctl.HIin = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer. Each instruction walks through fetch and execute, and the strobes, register selects, OP and Run are compared in every state.
module tb_alu_sequencer;
    localparam int NREGS = 16;
    localparam int OPW   = 5;

    localparam logic [15:0] S_PCOUT  = 16'h8000, S_ZHOUT  = 16'h4000, S_ZLOUT = 16'h2000;
    localparam logic [15:0] S_MDROUT = 16'h1000, S_COUT   = 16'h0800, S_PCIN  = 16'h0400;
    localparam logic [15:0] S_IRIN   = 16'h0200, S_MARIN  = 16'h0100, S_MDRIN = 16'h0080;
    localparam logic [15:0] S_YIN    = 16'h0040, S_ZHIN   = 16'h0020, S_ZLIN  = 16'h0010;
    localparam logic [15:0] S_HIIN   = 16'h0008, S_LOIN   = 16'h0004, S_INCPC = 16'h0002;
    localparam logic [15:0] S_READ   = 16'h0001;
    localparam logic [15:0] T0_S     = S_PCOUT | S_MARIN | S_INCPC | S_ZLIN | S_ZHIN;
    localparam logic [15:0] T1_WAIT  = S_ZLOUT | S_READ | S_MDRIN;
    localparam logic [15:0] T2_S     = S_MDROUT | S_IRIN;

    logic Clock;
    logic Clear;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   start;

    alu_sequencer_if #(.NREGS(NREGS), .OPW(OPW)) bus ();
    alu_sequencer #(.NREGS(NREGS), .OPW(OPW)) dut (.Clock(Clock), .Clear(Clear), .ctl(bus));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] strobes();
        return {bus.PCout, bus.ZHighout, bus.ZLowout, bus.MDRout, bus.Cout, bus.PCin,
                bus.IRin, bus.MARin, bus.MDRin, bus.Yin, bus.ZHighin, bus.ZLowin,
                bus.HIin, bus.LOin, bus.IncPC, bus.Read};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] s, input logic [15:0] rin,
                              input logic [15:0] rout, input logic run, input logic ill);
        check({tag, "_strobes"}, 32'(strobes()), 32'(s));
        check({tag, "_rin"}, 32'(bus.R_in), 32'(rin));
        check({tag, "_rout"}, 32'(bus.R_out), 32'(rout));
        check({tag, "_run"}, 32'(bus.Run), 32'(run));
        check({tag, "_illegal"}, 32'(bus.Illegal), 32'(ill));
    endtask

    // Entered with the DUT in T0. Returns with the DUT in the state after T2.
    task automatic fetch(input string tag, input logic [31:0] ir, input int waits);
        start = cyc;
        bus.IR = ir;
        bus.Mem_ready = (waits == 0);
        expect_out({tag, "_t0"}, T0_S, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        for (int w = 0; w < waits; w++) begin
            expect_out({tag, "_t1wait"}, T1_WAIT, 16'h0, 16'h0, 1'b1, 1'b0);
            tick();
        end
        bus.Mem_ready = 1'b1;
        #1;
        expect_out({tag, "_t1rdy"}, T1_WAIT | S_PCIN, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        expect_out({tag, "_t2"}, T2_S, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
    endtask

    initial begin
        Clear = 1'b1;
        bus.IR = 32'h0;
        bus.Mem_ready = 1'b0;
        bus.Stop = 1'b0;

        // Reset held for two edges, then T0 one cycle after release.
        tick();
        expect_out("rst1", 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
        check("rst1_op", 32'(bus.OP), 32'h0);
        tick();
        expect_out("rst2", 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
        Clear = 1'b0;
        tick();

        // rol R6,R6,R4
        fetch("rol", 32'h4B320000, 0);
        expect_out("rol_t3", S_YIN, 16'h0, 16'h0040, 1'b1, 1'b0);
        tick();
        expect_out("rol_t4", S_ZLIN | S_ZHIN, 16'h0, 16'h0010, 1'b1, 1'b0);
        check("rol_op", 32'(bus.OP), 32'h09);
        tick();
        expect_out("rol_t5", S_ZLOUT, 16'h0040, 16'h0, 1'b1, 1'b0);
        tick();
        check("rol_cycles", cyc - start, 6);

        // addi R3,R4,-5
        fetch("addi", 32'h61A7FFFB, 0);
        expect_out("addi_t3", S_YIN, 16'h0, 16'h0010, 1'b1, 1'b0);
        tick();
        expect_out("addi_t4", S_COUT | S_ZLIN | S_ZHIN, 16'h0, 16'h0, 1'b1, 1'b0);
        check("addi_op", 32'(bus.OP), 32'h03);
        tick();
        expect_out("addi_t5", S_ZLOUT, 16'h0008, 16'h0, 1'b1, 1'b0);
        tick();
        check("addi_cycles", cyc - start, 6);

        // mul R2,R5
        fetch("mul", 32'h79280000, 0);
        expect_out("mul_t3", S_YIN, 16'h0, 16'h0004, 1'b1, 1'b0);
        tick();
        expect_out("mul_t4", S_ZLIN | S_ZHIN, 16'h0, 16'h0020, 1'b1, 1'b0);
        check("mul_op", 32'(bus.OP), 32'h0F);
        tick();
        expect_out("mul_t5", S_ZLOUT | S_LOIN, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        expect_out("mul_t6", S_ZHOUT | S_HIIN, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        check("mul_cycles", cyc - start, 7);

        // neg R1,R7 with three memory wait cycles. T3 is skipped.
        fetch("neg", 32'h88B80000, 3);
        expect_out("neg_t4", S_ZLIN, 16'h0, 16'h0080, 1'b1, 1'b0);
        check("neg_op", 32'(bus.OP), 32'h11);
        tick();
        expect_out("neg_t5", S_ZLOUT, 16'h0002, 16'h0, 1'b1, 1'b0);
        tick();
        check("neg_cycles", cyc - start, 8);

        // Clear during a fetch wait returns the DUT to RST, which drops Read.
        bus.IR = 32'h4B320000;
        bus.Mem_ready = 1'b0;
        tick();
        expect_out("clrw_t1", T1_WAIT, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        expect_out("clrw_t1b", T1_WAIT, 16'h0, 16'h0, 1'b1, 1'b0);
        Clear = 1'b1;
        tick();
        expect_out("clrw_rst", 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
        check("clrw_op", 32'(bus.OP), 32'h0);
        Clear = 1'b0;
        tick();

        // and R1,R2,R3. Stop is raised in T5, the instruction completes, and the DUT pauses after the next T0.
        fetch("and", 32'h50918000, 0);
        expect_out("and_t3", S_YIN, 16'h0, 16'h0004, 1'b1, 1'b0);
        tick();
        expect_out("and_t4", S_ZLIN | S_ZHIN, 16'h0, 16'h0008, 1'b1, 1'b0);
        tick();
        expect_out("and_t5", S_ZLOUT, 16'h0002, 16'h0, 1'b1, 1'b0);
        bus.Stop = 1'b1;
        tick();
        check("and_cycles", cyc - start, 6);
        expect_out("stop_t0", T0_S, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        expect_out("pause1", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        expect_out("pause2", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        check("pause_op", 32'(bus.OP), 32'h0A);
        bus.Stop = 1'b0;
        tick();

        // nop goes from T2 straight back to T0.
        fetch("nop", 32'hD0000000, 0);
        check("nop_t0", 32'(bus.PCout), 32'h1);
        check("nop_cycles", cyc - start, 3);

        // An undefined opcode pulses Illegal for one cycle and writes nothing.
        fetch("ill", 32'hF8000000, 0);
        expect_out("ill_t3", 16'h0, 16'h0, 16'h0, 1'b1, 1'b1);
        tick();
        check("ill_cycles", cyc - start, 4);
        check("ill_op", 32'(bus.OP), 32'h0A);

        // halt: outputs stay frozen while Stop and Mem_ready are toggled.
        fetch("halt", 32'hD8000000, 0);
        for (int i = 0; i < 20; i++) begin
            bus.Stop = i[0];
            bus.Mem_ready = i[1];
            #1;
            expect_out("halt", 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
            check("halt_op", 32'(bus.OP), 32'h0A);
            tick();
        end
        bus.Stop = 1'b0;
        Clear = 1'b1;
        tick();
        expect_out("halt_clr", 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
        Clear = 1'b0;
        tick();
        expect_out("halt_t0", T0_S, 16'h0, 16'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
